// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the Pong match sequencer.
// Contents: state encodings, score packing offsets, counter width,
// keyboard scan codes that the key decoder maps onto key_start/key_pause,
// and a saturation-free per-side score increment helper.
package pong_game_ctrl_pkg;

   localparam int unsigned STATE_W     = 3;
   localparam int unsigned SCORE_W     = 4;
   localparam int unsigned SIDE_W      = 2;
   localparam int unsigned SCORE_L_LSB = 2;
   localparam int unsigned SCORE_R_LSB = 0;
   localparam int unsigned CNT_W       = 8;

   localparam logic [7:0] SCAN_START = 8'h29;  // space bar
   localparam logic [7:0] SCAN_PAUSE = 8'h4D;  // 'P'

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_POINT = 3'd4,
      S_OVER  = 3'd5
   } state_e;

   // One side's score plus one; cannot wrap because WIN_SCORE <= 3 ends the match.
   function automatic logic [SIDE_W-1:0] side_inc(input logic [SIDE_W-1:0] s);
      return s + SIDE_W'(1);
   endfunction

endpackage

// File: rtl/pong_game_ctrl_key_edge.sv
// Press-event detector for one keyboard level signal.
// Ports: clk, rst_n (async active-low), key_i (level), press_c (combinational
// press event = key_i & ~history). History resets high so a key held through
// reset release yields no event until it is released and pressed again.
module pong_game_ctrl_key_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_c
);

   logic key_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) key_q <= 1'b1;
      else        key_q <= key_i;
   end

   assign press_c = key_i & ~key_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match-level sequencer for Pong: scores, serve timing, ball/paddle control.
// Ports: vga_clk, sys_rst_n (async active-low), frame_tick (per-frame pulse),
// key_start/key_pause (key levels), point_l/point_r (score pulses);
// outputs start (ball enable), guiwei (reposition pulse), score {l,r},
// serve_dir, game_over, winner, state (debug). All outputs registered.
// Build option: define PONG_PAUSE_EN to enable the PAUSE state.
module pong_game_ctrl
   import pong_game_ctrl_pkg::*;
#(
   parameter logic [1:0] WIN_SCORE    = 2'd3,
   parameter logic [7:0] SERVE_FRAMES = 8'd60,
   parameter logic [7:0] POINT_FRAMES = 8'd90
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       frame_tick,
   input  logic       key_start,
   input  logic       key_pause,
   input  logic       point_l,
   input  logic       point_r,
   output logic       start,
   output logic       guiwei,
   output logic [3:0] score,
   output logic       serve_dir,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   state_e               state_q, state_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 start_q, start_d;
   logic                 guiwei_q, guiwei_d;
   logic                 dir_q, dir_d;
   logic                 over_q, over_d;
   logic                 winner_q, winner_d;
   logic [SIDE_W-1:0]    inc_l, inc_r;
   logic                 start_press_c;
   logic                 pause_press_c;

   pong_game_ctrl_key_edge u_key_start (
      .clk     (vga_clk),
      .rst_n   (sys_rst_n),
      .key_i   (key_start),
      .press_c (start_press_c)
   );

`ifdef PONG_PAUSE_EN
   pong_game_ctrl_key_edge u_key_pause (
      .clk     (vga_clk),
      .rst_n   (sys_rst_n),
      .key_i   (key_pause),
      .press_c (pause_press_c)
   );
`else
   logic unused_pause_c;
   assign unused_pause_c = key_pause;
   assign pause_press_c  = 1'b0;
`endif

   // State, score and output registers.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= S_IDLE;
         score_q  <= '0;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         guiwei_q <= 1'b0;
         dir_q    <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         guiwei_q <= guiwei_d;
         dir_q    <= dir_d;
         over_q   <= over_d;
         winner_q <= winner_d;
      end
   end

   // Next-state, score update and registered-output intent.
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      winner_d = winner_q;
      inc_l    = side_inc(score_q[SCORE_L_LSB +: SIDE_W]);
      inc_r    = side_inc(score_q[SCORE_R_LSB +: SIDE_W]);

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_press_c) begin
               state_d  = S_SERVE;
               score_d  = '0;
               cnt_d    = '0;
               dir_d    = 1'b0;
               winner_d = 1'b0;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (cnt_q == SERVE_FRAMES - 8'd1) begin
                  state_d = S_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_PLAY: begin
            // point_l has priority; a simultaneous point_r is dropped.
            if (point_l) begin
               score_d[SCORE_L_LSB +: SIDE_W] = inc_l;
               dir_d = 1'b1;
               cnt_d = '0;
               if (inc_l == WIN_SCORE) begin
                  state_d  = S_OVER;
                  winner_d = 1'b0;
               end else begin
                  state_d = S_POINT;
               end
            end else if (point_r) begin
               score_d[SCORE_R_LSB +: SIDE_W] = inc_r;
               dir_d = 1'b0;
               cnt_d = '0;
               if (inc_r == WIN_SCORE) begin
                  state_d  = S_OVER;
                  winner_d = 1'b1;
               end else begin
                  state_d = S_POINT;
               end
            end else if (pause_press_c) begin
               state_d = S_PAUSE;
            end
         end
`ifdef PONG_PAUSE_EN
         S_PAUSE: begin
            if (pause_press_c) state_d = S_PLAY;
         end
`endif
         S_POINT: begin
            if (frame_tick) begin
               if (cnt_q == POINT_FRAMES - 8'd1) begin
                  state_d = S_SERVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      start_d  = (state_d == S_PLAY);
      guiwei_d = (state_d == S_SERVE) && (state_q != S_SERVE);
      over_d   = (state_d == S_OVER);
   end

   assign start     = start_q;
   assign guiwei    = guiwei_q;
   assign score     = score_q;
   assign serve_dir = dir_q;
   assign game_over = over_q;
   assign winner    = winner_q;
   assign state     = state_q;

endmodule
